// File: rtl/dx_io_buf.sv
// dx_io_buf: per-bit bidirectional pad buffer. Each bit drives its pad from
// the core or releases it to Z. The resolved pad level always returns to the
// core. The output path can be registered once, and the input path can carry
// a 0..3 stage synchroniser.
module dx_io_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_REG    = 0,
    parameter int IN_SYNC    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] dio_t,
    input  logic [DATA_WIDTH-1:0] dio_o,
    output logic [DATA_WIDTH-1:0] dio_i,
    inout  wire  [DATA_WIDTH-1:0] dio_p
);

    // Out-of-range configurations stop elaboration.
    if (DATA_WIDTH < 1 || DATA_WIDTH > 64) begin : g_bad_width
        $fatal(1, "dx_io_buf: DATA_WIDTH must be 1..64");
    end
    if (OUT_REG < 0 || OUT_REG > 1) begin : g_bad_out_reg
        $fatal(1, "dx_io_buf: OUT_REG must be 0 or 1");
    end
    if (IN_SYNC < 0 || IN_SYNC > 3) begin : g_bad_in_sync
        $fatal(1, "dx_io_buf: IN_SYNC must be 0..3");
    end

    // Effective tri-state control and data presented to the pad drivers.
    logic [DATA_WIDTH-1:0] t_eff;
    logic [DATA_WIDTH-1:0] o_eff;

    if (OUT_REG == 1) begin : g_out_reg
        logic [DATA_WIDTH-1:0] t_reg;
        logic [DATA_WIDTH-1:0] o_reg;

        // Output stage: register control and data; reset releases every pad.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                t_reg <= '1;
                o_reg <= '0;
            end else begin
                t_reg <= dio_t;
                o_reg <= dio_o;
            end
        end

        assign t_eff = t_reg;
        assign o_eff = o_reg;
    end else begin : g_out_comb
        assign t_eff = dio_t;
        assign o_eff = dio_o;
    end

    // Pad drivers: each bit is driven only while its control is low.
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_pad
        assign dio_p[i] = t_eff[i] ? 1'bz : o_eff[i];
    end

    if (IN_SYNC > 0) begin : g_in_sync
        logic [DATA_WIDTH-1:0] sync_p [IN_SYNC];

        // Input stage: shift the resolved pad level through the synchroniser.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int s = 0; s < IN_SYNC; s++) begin
                    sync_p[s] <= '0;
                end
            end else begin
                sync_p[0] <= dio_p;
                for (int s = 1; s < IN_SYNC; s++) begin
                    sync_p[s] <= sync_p[s-1];
                end
            end
        end

        assign dio_i = sync_p[IN_SYNC-1];
    end else begin : g_in_comb
        assign dio_i = dio_p;
    end

    // Fully combinational builds have no registers, so clock and reset are
    // intentionally left unused there.
    if (OUT_REG == 0 && IN_SYNC == 0) begin : g_no_clk
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
    end

endmodule

// File: tb/tb_dx_io_buf.sv
// tb_dx_io_buf: scoreboard bench for dx_io_buf. dut0 is the combinational
// build (OUT_REG=0, IN_SYNC=0). dut1 is the clocked build (OUT_REG=1,
// IN_SYNC=2). Expected pad and dio_i values come from a word-level model:
// the pad is the core data on driven bits and the external data on released
// bits.
module tb_dx_io_buf;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;

    // dut0 signals
    logic [7:0] dio_t0 = 8'hFF;
    logic [7:0] dio_o0 = 8'h00;
    logic [7:0] dio_i0;
    wire  [7:0] pad0;
    logic [7:0] ext_en0  = 8'h00;
    logic [7:0] ext_val0 = 8'h00;

    // dut1 signals
    logic [7:0] dio_t1 = 8'hFF;
    logic [7:0] dio_o1 = 8'h00;
    logic [7:0] dio_i1;
    wire  [7:0] pad1;
    logic [7:0] ext_en1  = 8'hFF;
    logic [7:0] ext_val1 = 8'hA5;

    for (genvar i = 0; i < 8; i++) begin : g_ext
        assign pad0[i] = ext_en0[i] ? ext_val0[i] : 1'bz;
        assign pad1[i] = ext_en1[i] ? ext_val1[i] : 1'bz;
    end

    dx_io_buf #(.DATA_WIDTH(8), .OUT_REG(0), .IN_SYNC(0)) dut0 (
        .clk(clk), .rst(rst), .dio_t(dio_t0), .dio_o(dio_o0),
        .dio_i(dio_i0), .dio_p(pad0)
    );

    dx_io_buf #(.DATA_WIDTH(8), .OUT_REG(1), .IN_SYNC(2)) dut1 (
        .clk(clk), .rst(rst), .dio_t(dio_t1), .dio_o(dio_o1),
        .dio_i(dio_i1), .dio_p(pad1)
    );

    // Scoreboard entry: which output, at which cycle, with the expected value
    // and the bits that carry a defined level.
    typedef struct {
        int         due;
        int         sel;   // 0 pad0, 1 dio_i0, 2 pad1, 3 dio_i1
        logic [7:0] exp;
        logic [7:0] mask;
        string      name;
    } chk_t;

    chk_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Insert a check, keeping the queue ordered by due cycle.
    function automatic void push(int due, int sel, logic [7:0] exp,
                                 logic [7:0] mask, string name);
        chk_t e;
        int   k;
        e.due = due; e.sel = sel; e.exp = exp; e.mask = mask; e.name = name;
        k = q.size();
        while (k > 0 && q[k-1].due > due) k--;
        q.insert(k, e);
    endfunction

    // Reference model: resolved pad word.
    function automatic logic [7:0] pad_model(logic [7:0] t, logic [7:0] o,
                                             logic [7:0] e);
        return (o & ~t) | (e & t);
    endfunction

    // Cycle counter, advanced on each rising edge.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: every falling edge, compare all checks due by this cycle.
    initial forever begin
        @(negedge clk);
        while (q.size() > 0 && q[0].due <= cyc) begin
            chk_t       e;
            logic [7:0] act;
            e = q.pop_front();
            case (e.sel)
                0:       act = pad0;
                1:       act = dio_i0;
                2:       act = pad1;
                default: act = dio_i1;
            endcase
            n_tests++;
            if ((act & e.mask) !== (e.exp & e.mask)) begin
                n_fail++;
                $display("FAIL %s cyc=%0d actual=%h expected=%h mask=%h",
                         e.name, cyc, act, e.exp, e.mask);
            end
        end
    end

    // dut0: apply one word and queue same-cycle checks on the defined bits.
    task automatic step0(logic [7:0] t, logic [7:0] o, logic [7:0] e,
                         logic [7:0] en, string name);
        logic [7:0] m;
        dio_t0 = t; dio_o0 = o; ext_en0 = en; ext_val0 = e;
        m = ~t | en;
        push(cyc, 0, pad_model(t, o, e & en), m, {name, "_pad"});
        push(cyc, 1, pad_model(t, o, e & en), m, {name, "_din"});
    endtask

    // dut1 model state: the word registered at the coming edge.
    logic [7:0] prev_t = 8'hFF;
    logic [7:0] prev_e = 8'hA5;

    // dut1: the word applied now reaches the pad after one edge and dio_i
    // after three. The external driver follows the control already registered.
    task automatic step1(logic [7:0] t, logic [7:0] o, logic [7:0] e,
                         string name);
        logic [7:0] p;
        dio_t1 = t; dio_o1 = o;
        ext_en1 = prev_t; ext_val1 = prev_e;
        prev_t = t; prev_e = e;
        p = pad_model(t, o, e);
        push(cyc + 1, 2, p, 8'hFF, {name, "_pad"});
        push(cyc + 3, 3, p, 8'hFF, {name, "_din"});
    endtask

    // Stimulus
    initial begin
        logic [7:0] rt, ro, re;

        // Phase A: dut1 held in reset while dut0 is exercised.
        @(posedge clk); #1;
        push(cyc, 2, 8'hA5, 8'hFF, "rst_pad1_released");
        push(cyc, 3, 8'h00, 8'hFF, "rst_din1_zero");
        step0(8'hFF, 8'h3C, 8'hA5, 8'hFF, "in_mode");
        #1;
        n_tests++;
        if (pad0 !== 8'hA5 || dio_i0 !== 8'hA5) begin
            n_fail++;
            $display("FAIL in_mode_direct pad=%h din=%h", pad0, dio_i0);
        end

        @(posedge clk); #1;
        step0(8'h00, 8'h3C, 8'h00, 8'h00, "out_mode");
        #1;
        n_tests++;
        if (pad0 !== 8'h3C || dio_i0 !== 8'h3C) begin
            n_fail++;
            $display("FAIL out_mode_direct pad=%h din=%h", pad0, dio_i0);
        end

        @(posedge clk); #1;
        step0(8'hF0, 8'h0F, 8'h90, 8'hF0, "mixed");
        #1;
        n_tests++;
        if (pad0 !== 8'h9F || dio_i0 !== 8'h9F) begin
            n_fail++;
            $display("FAIL mixed_direct pad=%h din=%h", pad0, dio_i0);
        end

        for (int n = 0; n < 50; n++) begin
            @(posedge clk); #1;
            rt = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
            ro = 8'($urandom);
            re = 8'($urandom);
            step0(rt, ro, re, rt, "rand0");
            push(cyc, 2, 8'hA5, 8'hFF, "rst_pad1_hold");
            push(cyc, 3, 8'h00, 8'hFF, "rst_din1_hold");
        end

        // Phase B: release reset and drive dut1.
        @(posedge clk); #1;
        rst = 1'b1;
        step1(8'h00, 8'h55, 8'h00, "drive55");

        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            rt = 8'($urandom);
            ro = 8'($urandom);
            re = 8'($urandom);
            step1(rt, ro, re, "rand1");
        end

        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            step1(8'h00, 8'h3C, 8'h00, "hold3c");
        end
        repeat (4) begin
            @(posedge clk); #1;
            ext_en1 = prev_t;
        end

        // Reset asserted between edges while pads are driven.
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        ext_en1 = 8'hFF; ext_val1 = 8'hAA;
        push(cyc, 2, 8'hAA, 8'hFF, "midrst_pad1_released");
        push(cyc, 3, 8'h00, 8'hFF, "midrst_din1_zero");
        #1;
        n_tests++;
        if (pad1 !== 8'hAA) begin
            n_fail++;
            $display("FAIL midrst_pad1_direct pad=%h", pad1);
        end
        n_tests++;
        if (dio_i1 !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_din1_direct din=%h", dio_i1);
        end

        // Drain the scoreboard within a bounded number of cycles.
        for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge clk);
        @(negedge clk); #1;
        while (q.size() > 0) begin
            chk_t e;
            e = q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s never checked (due=%0d, now=%0d)", e.name, e.due, cyc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
